// File: rtl/sa_in_sequencer.sv
// Input sequencer for the SA attention core: buffers one task (input rows plus
// W_Q/W_K/W_V), replays it as a gap-free 192-cycle burst, then waits for SA's results.
module sa_in_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid_i,
  input  logic [3:0]        cfg_T_i,
  output logic              cfg_ready_o,
  input  logic              s_valid_i,
  input  logic signed [7:0] s_data_i,
  output logic              s_ready_o,
  output logic              in_valid_o,
  output logic [3:0]        T_o,
  output logic signed [7:0] in_data_o,
  output logic signed [7:0] w_Q_o,
  output logic signed [7:0] w_K_o,
  output logic signed [7:0] w_V_o,
  input  logic              sa_out_valid_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] t_q, t_d;
  logic [6:0] out_cnt_q, out_cnt_d;

  logic              in_valid_q, in_valid_d;
  logic [3:0]        t_out_q, t_out_d;
  logic signed [7:0] in_data_q, in_data_d;
  logic signed [7:0] w_q_q, w_q_d;
  logic signed [7:0] w_k_q, w_k_d;
  logic signed [7:0] w_v_q, w_v_d;

  // Fixed layout: data 0..63, W_Q 64..127, W_K 128..191, W_V 192..255.
  logic signed [7:0] mem_q [256];

  logic       cfg_t_legal;
  logic [6:0] rows8;
  logic [8:0] load_last;
  logic [7:0] wr_ptr_inc;
  logic       data_done;
  logic [6:0] out_cnt_inc;
  logic [7:0] k;
  logic       wr_en;

  assign cfg_t_legal = (cfg_T_i == 4'd1) || (cfg_T_i == 4'd4) || (cfg_T_i == 4'd8);
  assign rows8       = {t_q, 3'b000};
  assign load_last   = {2'b00, rows8} + 9'd191;
  assign wr_ptr_inc  = wr_ptr_q + 8'd1;
  // Short data sections skip the unused tail of the data region so weights always land at 64.
  assign data_done   = (wr_ptr_q[7:6] == 2'b00) && (wr_ptr_inc[6:0] == rows8);
  assign out_cnt_inc = out_cnt_q + 7'd1;
  assign k           = cnt_q[7:0];
  assign wr_en       = (state_q == S_LOAD) && s_valid_i;

  assign cfg_ready_o = (state_q == S_IDLE);
  assign s_ready_o   = (state_q == S_LOAD);
  assign busy_o      = (state_q != S_IDLE);

  assign in_valid_o  = in_valid_q;
  assign T_o         = t_out_q;
  assign in_data_o   = in_data_q;
  assign w_Q_o       = w_q_q;
  assign w_K_o       = w_k_q;
  assign w_V_o       = w_v_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    t_d       = t_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid_i && cfg_t_legal) begin
          t_d       = cfg_T_i;
          cnt_d     = 9'd0;
          wr_ptr_d  = 8'd0;
          out_cnt_d = 7'd0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_valid_i) begin
          cnt_d    = cnt_q + 9'd1;
          wr_ptr_d = data_done ? 8'd64 : wr_ptr_inc;
          if (cnt_q == load_last) begin
            cnt_d   = 9'd0;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (k == 8'd191) begin
          cnt_d   = 9'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_WAIT: begin
        if (sa_out_valid_i) begin
          out_cnt_d = out_cnt_inc;
          if (out_cnt_inc == rows8) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst lane k maps straight onto the buffer: bits [7:6] select the weight section.
  always_comb begin
    in_valid_d = 1'b0;
    t_out_d    = 4'd0;
    in_data_d  = 8'sd0;
    w_q_d      = 8'sd0;
    w_k_d      = 8'sd0;
    w_v_d      = 8'sd0;
    if (state_q == S_SEND) begin
      in_valid_d = 1'b1;
      if (k == 8'd0) begin
        t_out_d = t_q;
      end
      if (cnt_q < {2'b00, rows8}) begin
        in_data_d = mem_q[{2'b00, k[5:0]}];
      end
      case (k[7:6])
        2'b00:   w_q_d = mem_q[{2'b01, k[5:0]}];
        2'b01:   w_k_d = mem_q[{2'b10, k[5:0]}];
        2'b10:   w_v_d = mem_q[{2'b11, k[5:0]}];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 9'd0;
      wr_ptr_q   <= 8'd0;
      t_q        <= 4'd0;
      out_cnt_q  <= 7'd0;
      in_valid_q <= 1'b0;
      t_out_q    <= 4'd0;
      in_data_q  <= 8'sd0;
      w_q_q      <= 8'sd0;
      w_k_q      <= 8'sd0;
      w_v_q      <= 8'sd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      t_q        <= t_d;
      out_cnt_q  <= out_cnt_d;
      in_valid_q <= in_valid_d;
      t_out_q    <= t_out_d;
      in_data_q  <= in_data_d;
      w_q_q      <= w_q_d;
      w_k_q      <= w_k_d;
      w_v_q      <= w_v_d;
    end
  end

  // Buffer contents need no reset: every byte read in a burst is rewritten during LOAD.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

endmodule

// File: tb/tb_sa_in_sequencer.sv
// Bench for sa_in_sequencer: table of cfg requests plus hand-written sequences,
// with a queue of expected burst beats compared as the DUT emits them.
module tb_sa_in_sequencer;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [3:0]        cfg_T = 4'd0;
  logic              cfg_ready;
  logic              s_valid = 1'b0;
  logic signed [7:0] s_data = 8'sd0;
  logic              s_ready;
  logic              in_valid;
  logic [3:0]        T;
  logic signed [7:0] in_data, w_Q, w_K, w_V;
  logic              sa_out_valid = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  sa_in_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_T_i(cfg_T), .cfg_ready_o(cfg_ready),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .in_valid_o(in_valid), .T_o(T), .in_data_o(in_data),
    .w_Q_o(w_Q), .w_K_o(w_K), .w_V_o(w_V),
    .sa_out_valid_i(sa_out_valid), .busy_o(busy)
  );

  typedef struct {
    logic [3:0] cfg_t;
    bit         accept;
    bit         stall;
    bit         spec_pat;
  } vec_t;

  vec_t              vecs [7];
  logic [35:0]       sb [$];
  logic signed [7:0] stim [256];
  int                n_checks = 0;
  int                n_fail = 0;
  int                run_len = 0;
  int                last_run = 0;
  bit                burst_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, then pop/compare any burst beat on display.
  task automatic tick();
    logic [35:0] exp;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      run_len = 0;
    end else if (in_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got in_valid=1 expected no burst");
      end else begin
        exp = sb.pop_front();
        check($sformatf("beat k=%0d", run_len), {T, in_data, w_Q, w_K, w_V}, exp);
      end
      run_len++;
    end else if (run_len != 0) begin
      last_run   = run_len;
      run_len    = 0;
      burst_done = 1'b1;
    end
  endtask

  task automatic issue_cfg(input logic [3:0] t, input bit accept, input bit hold);
    cfg_valid = 1'b1;
    cfg_T     = t;
    tick();
    if (!hold) cfg_valid = 1'b0;
    check($sformatf("cfg T=%0d cfg_ready", t), cfg_ready, !accept);
    check($sformatf("cfg T=%0d s_ready", t), s_ready, accept);
    check($sformatf("cfg T=%0d busy", t), busy, accept);
    $display("cfg request T=%0d accepted=%0d", t, cfg_ready ? 0 : 1);
  endtask

  task automatic load(input int t, input bit stall, input bit spec_pat);
    int t8, n, idx, guard;
    bit hs;
    logic [3:0] rt;
    logic signed [7:0] d, q, kk, v;
    t8 = t * 8;
    n  = t8 + 192;
    for (int i = 0; i < n; i++) begin
      if (spec_pat) stim[i] = (i < 8) ? 8'(i + 1) : 8'sd1;
      else          stim[i] = 8'($urandom_range(0, 255));
    end
    for (int kb = 0; kb < 192; kb++) begin
      rt = (kb == 0) ? 4'(t) : 4'd0;
      d  = (kb < t8) ? stim[kb] : 8'sd0;
      q  = (kb < 64) ? stim[t8 + kb] : 8'sd0;
      kk = (kb >= 64 && kb < 128) ? stim[t8 + kb] : 8'sd0;
      v  = (kb >= 128) ? stim[t8 + kb] : 8'sd0;
      sb.push_back({rt, d, q, kk, v});
    end
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = stim[idx];
      hs      = s_valid && s_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    s_valid = 1'b0;
    check($sformatf("T=%0d handshakes", t), idx, n);
    check($sformatf("T=%0d s_ready after last byte", t), s_ready, 0);
  endtask

  task automatic wait_burst(input bit spam);
    int guard;
    burst_done = 1'b0;
    guard = 0;
    while (!burst_done && guard < 600) begin
      // Pulse only while the DUT is still in SEND (visible beat k < 191).
      sa_out_valid = spam && in_valid && (run_len <= 191);
      tick();
      guard++;
    end
    sa_out_valid = 1'b0;
    if (!burst_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: got no completed burst expected one within 600 cycles");
    end
    check("burst length", last_run, 192);
    check("scoreboard drained", sb.size(), 0);
    check("outputs zero after burst", {in_valid, T, in_data, w_Q, w_K, w_V}, 0);
    $display("burst done length=%0d", last_run);
  endtask

  task automatic drain(input int t);
    int t8;
    t8 = t * 8;
    for (int i = 0; i < t8; i++) begin
      sa_out_valid = 1'b1;
      tick();
      sa_out_valid = 1'b0;
      if (i == t8 - 2) begin
        check($sformatf("T=%0d busy before last result", t), busy, 1);
        check($sformatf("T=%0d cfg_ready before last result", t), cfg_ready, 0);
      end
      if (i == t8 - 1) begin
        check($sformatf("T=%0d cfg_ready after last result", t), cfg_ready, 1);
        check($sformatf("T=%0d busy after last result", t), busy, 0);
      end else begin
        tick();
      end
    end
    $display("task T=%0d results drained", t);
  endtask

  initial begin
    int guard;
    vecs[0] = '{cfg_t: 4'd1,  accept: 1'b1, stall: 1'b0, spec_pat: 1'b1};
    vecs[1] = '{cfg_t: 4'd8,  accept: 1'b1, stall: 1'b1, spec_pat: 1'b0};
    vecs[2] = '{cfg_t: 4'd5,  accept: 1'b0, stall: 1'b0, spec_pat: 1'b0};
    vecs[3] = '{cfg_t: 4'd0,  accept: 1'b0, stall: 1'b0, spec_pat: 1'b0};
    vecs[4] = '{cfg_t: 4'd4,  accept: 1'b1, stall: 1'b0, spec_pat: 1'b0};
    vecs[5] = '{cfg_t: 4'd12, accept: 1'b0, stall: 1'b0, spec_pat: 1'b0};
    vecs[6] = '{cfg_t: 4'd4,  accept: 1'b1, stall: 1'b1, spec_pat: 1'b0};

    repeat (3) tick();
    check("reset cfg_ready", cfg_ready, 1);
    check("reset s_ready", s_ready, 0);
    check("reset busy", busy, 0);
    check("reset outputs", {in_valid, T, in_data, w_Q, w_K, w_V}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      issue_cfg(vecs[i].cfg_t, vecs[i].accept, 1'b0);
      if (vecs[i].accept) begin
        load(int'(vecs[i].cfg_t), vecs[i].stall, vecs[i].spec_pat);
        wait_burst(1'b0);
        drain(int'(vecs[i].cfg_t));
      end
    end

    // SA results pulsed during SEND must not count toward completion.
    issue_cfg(4'd4, 1'b1, 1'b0);
    load(4, 1'b0, 1'b0);
    wait_burst(1'b1);
    drain(4);

    // Asynchronous reset in the middle of a burst.
    issue_cfg(4'd1, 1'b1, 1'b0);
    load(1, 1'b0, 1'b0);
    guard = 0;
    while (run_len < 101 && guard < 400) begin
      tick();
      guard++;
    end
    check("reached beat k=100", run_len, 101);
    rst_n = 1'b0;
    #1;
    check("midsend reset in_valid", in_valid, 0);
    check("midsend reset outputs", {T, in_data, w_Q, w_K, w_V}, 0);
    check("midsend reset cfg_ready", cfg_ready, 1);
    check("midsend reset busy", busy, 0);
    check("midsend reset s_ready", s_ready, 0);
    $display("reset applied at beat k=100");
    tick();
    rst_n = 1'b1;
    tick();
    issue_cfg(4'd1, 1'b1, 1'b0);
    load(1, 1'b0, 1'b0);
    wait_burst(1'b0);
    drain(1);

    // Back-to-back tasks with cfg_valid held high throughout.
    issue_cfg(4'd8, 1'b1, 1'b1);
    cfg_T = 4'd1;
    load(8, 1'b0, 1'b0);
    wait_burst(1'b0);
    drain(8);
    tick();
    check("b2b second accepted s_ready", s_ready, 1);
    check("b2b second accepted cfg_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    $display("back-to-back second task accepted");
    load(1, 1'b0, 1'b0);
    wait_burst(1'b0);
    drain(1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
